// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_fifo: synchronous write port, combinational read port.
module handshake_fifo_mem #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic req/ack buffer between an arf out port (upstream) and a pulse-acked consumer (downstream).
// Handshake: upstream delivers a word on any edge with din_ack=1; downstream sees one dout_ack pulse per word.
module handshake_fifo #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    localparam int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  din_req,
    input  logic                  din_ack,
    input  logic [data_width-1:0] din,
    input  logic                  dout_req,
    output logic                  dout_ack,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   count,
    output logic                  overflow
);

    localparam logic [addr_width:0]   cnt_full  = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   req_limit = (addr_width+1)'(depth - 2);
    localparam logic [addr_width:0]   cnt_one   = (addr_width+1)'(1);
    localparam logic [addr_width-1:0] ptr_one   = addr_width'(1);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count_next;
    logic [data_width-1:0] rdata;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  drop;

    always_comb begin
        full       = 1'b0;
        pop        = 1'b0;
        push_ok    = 1'b0;
        drop       = 1'b0;
        count_next = count;

        full = (count == cnt_full);
        // A pop is never issued back-to-back: dout_ack must return low between words.
        pop  = dout_req && !dout_ack && (count != '0);
        // At full, a push is still legal if a pop frees the slot on the same edge.
        push_ok = din_ack && (!full || pop);
        drop    = din_ack && full && !pop;

        if (push_ok && !pop) begin
            count_next = count + cnt_one;
        end else if (pop && !push_ok) begin
            count_next = count - cnt_one;
        end
    end

    handshake_fifo_mem #(
        .data_width(data_width),
        .depth     (depth)
    ) u_mem (
        .clk  (clk),
        .we   (push_ok && rst),
        .waddr(wr_ptr),
        .wdata(din),
        .raddr(rd_ptr),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            din_req  <= 1'b0;
            dout_ack <= 1'b0;
            dout     <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            // Two slots of headroom: upstream may still ack once after req drops.
            din_req  <= (count_next <= req_limit);
            dout_ack <= pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ptr_one;
            end
            if (pop) begin
                dout   <= rdata;
                rd_ptr <= rd_ptr + ptr_one;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed self-checking bench for handshake_fifo (data_width=32, depth=4).
module tb_handshake_fifo;

    logic        clk;
    logic        rst;
    logic        din_req;
    logic        din_ack;
    logic [31:0] din;
    logic        dout_req;
    logic        dout_ack;
    logic [31:0] dout;
    logic [2:0]  count;
    logic        overflow;

    int tests;
    int fails;
    logic [31:0] exp_q[$];

    handshake_fifo #(
        .data_width(32),
        .depth     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din_req (din_req),
        .din_ack (din_ack),
        .din     (din),
        .dout_req(dout_req),
        .dout_ack(dout_ack),
        .dout    (dout),
        .count   (count),
        .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b0;
        din_ack  = 1'b0;
        dout_req = 1'b0;
        repeat (n) step();
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic push_direct(input logic [31:0] w);
        din_ack = 1'b1;
        din     = w;
        exp_q.push_back(w);
        step();
        din_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        din_ack  = 1'b1;
        din      = 32'd7;
        dout_req = 1'b0;
        step();
        step();
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (dout_ack !== 1'b0) begin fails++; $display("FAIL reset_dout_ack got=%b exp=0", dout_ack); end
        tests++; if (dout !== 32'd0) begin fails++; $display("FAIL reset_dout got=%h exp=0", dout); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        tests++; if (din_req !== 1'b0) begin fails++; $display("FAIL reset_din_req got=%b exp=0", din_req); end
        rst     = 1'b1;
        din_ack = 1'b0;
        step();
        tests++; if (din_req !== 1'b1) begin fails++; $display("FAIL reset_release_din_req got=%b exp=1", din_req); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_release_count got=%0d exp=0", count); end
    endtask

    task automatic test_pass_through();
        int sent;
        int received;
        int max_cnt;
        logic prev_ack;
        logic [31:0] last_dout;
        logic [31:0] exp;
        do_reset(1);
        step();
        sent      = 0;
        received  = 0;
        max_cnt   = 0;
        prev_ack  = 1'b0;
        last_dout = dout;
        dout_req  = 1'b1;
        for (int cyc = 0; cyc < 1000 && received < 100; cyc++) begin
            // Producer: pulses ack in response to req, never two cycles in a row.
            if (sent < 100 && din_req && !din_ack) begin
                din_ack = 1'b1;
                din     = 32'(sent);
                exp_q.push_back(32'(sent));
                sent++;
            end else begin
                din_ack = 1'b0;
            end
            step();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (dout_ack) begin
                tests++; if (prev_ack) begin fails++; $display("FAIL pass_ack_width word=%0d ack high two cycles", received); end
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                tests++; if (dout !== exp) begin fails++; $display("FAIL pass_data got=%0d exp=%0d", dout, exp); end
                received++;
                last_dout = dout;
            end else begin
                tests++; if (dout !== last_dout) begin fails++; $display("FAIL pass_dout_hold got=%0d exp=%0d", dout, last_dout); end
            end
            prev_ack = dout_ack;
        end
        din_ack  = 1'b0;
        dout_req = 1'b0;
        step();
        tests++; if (received != 100) begin fails++; $display("FAIL pass_received got=%0d exp=100", received); end
        tests++; if (max_cnt > 2) begin fails++; $display("FAIL pass_max_count got=%0d exp<=2", max_cnt); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL pass_overflow got=%b exp=0", overflow); end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL pass_final_count got=%0d exp=0", count); end
    endtask

    task automatic test_backpressure();
        int sent;
        int received;
        int ack_cyc[3];
        logic [31:0] exp;
        do_reset(1);
        step();
        sent     = 0;
        dout_req = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (din_req && !din_ack) begin
                din_ack = 1'b1;
                din     = 32'(sent);
                exp_q.push_back(32'(sent));
                sent++;
            end else begin
                din_ack = 1'b0;
            end
            step();
            if (count == 3'd3) begin
                tests++; if (din_req !== 1'b0) begin fails++; $display("FAIL bp_req_drop got=%b exp=0 at count=3", din_req); end
            end
        end
        din_ack = 1'b0;
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL bp_count got=%0d exp=3", count); end
        tests++; if (sent != 3) begin fails++; $display("FAIL bp_sent got=%0d exp=3", sent); end
        dout_req = 1'b1;
        received = 0;
        for (int cyc = 0; cyc < 20 && received < 3; cyc++) begin
            step();
            if (dout_ack) begin
                exp = 32'(received);
                tests++; if (dout !== exp) begin fails++; $display("FAIL bp_data got=%0d exp=%0d", dout, exp); end
                ack_cyc[received] = cyc;
                received++;
            end
        end
        dout_req = 1'b0;
        exp_q.delete();
        tests++; if (received != 3) begin fails++; $display("FAIL bp_received got=%0d exp=3", received); end
        if (received == 3) begin
            tests++; if (ack_cyc[1] - ack_cyc[0] != 2 || ack_cyc[2] - ack_cyc[1] != 2) begin
                fails++; $display("FAIL bp_spacing got=%0d,%0d exp=2,2", ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
            end
        end
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL bp_final_count got=%0d exp=0", count); end
    endtask

    task automatic drain(input string tag, input int n_exp);
        int received;
        logic [31:0] exp;
        dout_req = 1'b1;
        received = 0;
        for (int cyc = 0; cyc < 40 && received < n_exp; cyc++) begin
            step();
            if (dout_ack) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                tests++; if (dout !== exp) begin fails++; $display("FAIL %s_data got=%h exp=%h", tag, dout, exp); end
                received++;
            end
        end
        tests++; if (received != n_exp) begin fails++; $display("FAIL %s_received got=%0d exp=%0d", tag, received, n_exp); end
        step();
        step();
        tests++; if (dout_ack !== 1'b0) begin fails++; $display("FAIL %s_extra_ack got=%b exp=0 dout=%h", tag, dout_ack, dout); end
        dout_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [31:0] exp;
        do_reset(1);
        for (int i = 0; i < 4; i++) push_direct(32'(10 + i));
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL sim_full_count got=%0d exp=4", count); end
        tests++; if (din_req !== 1'b0) begin fails++; $display("FAIL sim_full_req got=%b exp=0", din_req); end
        din_ack  = 1'b1;
        din      = 32'd14;
        dout_req = 1'b1;
        exp_q.push_back(32'd14);
        step();
        din_ack = 1'b0;
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL sim_count got=%0d exp=4", count); end
        tests++; if (dout_ack !== 1'b1) begin fails++; $display("FAIL sim_ack got=%b exp=1", dout_ack); end
        exp = exp_q.pop_front();
        tests++; if (dout !== exp) begin fails++; $display("FAIL sim_data got=%0d exp=%0d", dout, exp); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL sim_overflow got=%b exp=0", overflow); end
        drain("sim", 4);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL sim_final_count got=%0d exp=0", count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL sim_final_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_overflow();
        do_reset(1);
        for (int i = 0; i < 4; i++) push_direct(32'(20 + i));
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
        din_ack = 1'b1;
        din     = 32'hAA;
        step();
        din_ack = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        tests++; if (count !== 3'd4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", count); end
        repeat (3) step();
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        drain("ovf", 4);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky_after_drain got=%b exp=1", overflow); end
        do_reset(1);
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_reset_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_midstream();
        do_reset(1);
        for (int i = 0; i < 3; i++) push_direct(32'(30 + i));
        tests++; if (count !== 3'd3) begin fails++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
        rst     = 1'b0;
        din_ack = 1'b1;
        din     = 32'd99;
        step();
        rst     = 1'b1;
        din_ack = 1'b0;
        exp_q.delete();
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL mid_count got=%0d exp=0", count); end
        tests++; if (dout_ack !== 1'b0) begin fails++; $display("FAIL mid_ack got=%b exp=0", dout_ack); end
        push_direct(32'd40);
        drain("mid", 1);
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL mid_final_count got=%0d exp=0", count); end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        din_ack  = 1'b0;
        din      = '0;
        dout_req = 1'b0;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_simultaneous();
        test_overflow();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
